// File: rtl/generador_obstaculos_pkg.sv
// Shared constants for the obstacle lane: game-state codes, blank digit and the
// obstacle ROM, reused by the collision stage.
package generador_obstaculos_pkg;

    typedef enum logic [3:0] {
        ST_APAGADO   = 4'd0,
        ST_HOLA      = 4'd1,
        ST_PERSONAJE = 4'd2,
        ST_JUEGO     = 4'd3,
        ST_GP        = 4'd4,
        ST_YN        = 4'd5
    } presente_t;

    localparam logic [6:0] BLANK     = 7'b0000000;
    localparam logic [1:0] VD_PIERDE = 2'd1;

    localparam logic [6:0] OBS_ROM [10] = '{
        7'b0001111, 7'b1100011, 7'b0111000, 7'b0010011, 7'b1000001,
        7'b0111111, 7'b0110110, 7'b0010101, 7'b0110001, 7'b1111110
    };

    // Folds the low LFSR nibble (0..15) onto the ten ROM slots.
    function automatic logic [3:0] obs_idx(input logic [7:0] l);
        logic [3:0] n;
        n = l[3:0];
        return (n < 4'd10) ? n : n - 4'd10;
    endfunction

    function automatic logic [6:0] obs_rom(input logic [3:0] idx);
        return (idx < 4'd10) ? OBS_ROM[idx] : BLANK;
    endfunction

endpackage

// File: rtl/generador_obstaculos_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4; advances only while en is high.
module lfsr8 #(
    parameter logic [7:0] SEMILLA = 8'hA5
) (
    input  logic       clk_ob,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk_ob) begin
        if (rst) begin
            q <= SEMILLA;
        end else if (en) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/generador_obstaculos.sv
// Obstacle lane: a level-dependent prescaler shifts three 7-segment digits toward
// the hero, alternating random obstacles with blanks and scoring cleared ones.
module generador_obstaculos
    import generador_obstaculos_pkg::*;
#(
    parameter logic [23:0] PER0      = 24'd12_500_000,
    parameter logic [23:0] PER1      = 24'd9_000_000,
    parameter logic [23:0] PER2      = 24'd6_000_000,
    parameter logic [23:0] PER3      = 24'd3_500_000,
    parameter logic [7:0]  PTS_NIVEL = 8'd16,
    parameter logic [7:0]  SEMILLA   = 8'hA5
) (
    input  logic        clk_ob,
    input  logic        rst,
    input  logic [3:0]  presente,
    input  logic [1:0]  v_d,
    output logic [20:0] disp_obs,
    output logic        tick,
    output logic [7:0]  puntos,
    output logic [1:0]  nivel
);

    logic [23:0] presc;
    logic [23:0] per_act;
    logic [3:0]  presente_prev;
    logic        obs_sig;
    logic [7:0]  lfsr_q;
    logic        corriendo;
    logic        limpiar;
    logic [6:0]  entrada;
    logic [7:0]  puntos_nx;
    logic [1:0]  nivel_nx;

    function automatic logic [1:0] nivel_de(input logic [7:0] p);
        logic [7:0] q;
        q = p / PTS_NIVEL;
        return (q > 8'd3) ? 2'd3 : q[1:0];
    endfunction

    always_comb begin
        per_act = PER0;
        case (nivel)
            2'd0:    per_act = PER0;
            2'd1:    per_act = PER1;
            2'd2:    per_act = PER2;
            default: per_act = PER3;
        endcase
    end

    assign corriendo = (presente == ST_JUEGO || presente == ST_GP) && (v_d != VD_PIERDE);
    // Clearing fires continuously in apagado, but only on the entry cycle of hola.
    assign limpiar   = (presente == ST_APAGADO) ||
                       (presente == ST_HOLA && presente_prev != ST_HOLA);
    // ">=" lets a level change that lowers the period fire on the next running cycle.
    assign tick      = !rst && corriendo && (presc >= per_act - 24'd1);
    assign entrada   = obs_sig ? obs_rom(obs_idx(lfsr_q)) : BLANK;

    always_comb begin
        puntos_nx = puntos;
        if (disp_obs[6:0] != BLANK && puntos != 8'hFF) begin
            puntos_nx = puntos + 8'd1;
        end
        nivel_nx = nivel_de(puntos_nx);
    end

    always_ff @(posedge clk_ob) begin
        if (rst) begin
            presc         <= '0;
            disp_obs      <= '0;
            puntos        <= '0;
            nivel         <= '0;
            obs_sig       <= 1'b1;
            presente_prev <= ST_APAGADO;
        end else begin
            presente_prev <= presente;
            if (limpiar) begin
                presc    <= '0;
                disp_obs <= '0;
                puntos   <= '0;
                nivel    <= '0;
                obs_sig  <= 1'b1;
            end else if (tick) begin
                presc    <= '0;
                disp_obs <= {entrada, disp_obs[20:7]};
                puntos   <= puntos_nx;
                nivel    <= nivel_nx;
                obs_sig  <= ~obs_sig;
            end else if (corriendo) begin
                presc <= presc + 24'd1;
            end
        end
    end

    lfsr8 #(
        .SEMILLA(SEMILLA)
    ) u_lfsr (
        .clk_ob(clk_ob),
        .rst   (rst),
        .en    (corriendo),
        .q     (lfsr_q)
    );

endmodule

// File: tb/tb_generador_obstaculos.sv
// Bench for generador_obstaculos with short periods; a cycle model feeds a scoreboard
// of expected digit/score values that is drained on every DUT tick.
module tb_generador_obstaculos;

    logic        clk_ob;
    logic        rst;
    logic [3:0]  presente;
    logic [1:0]  v_d;
    logic [20:0] disp_obs;
    logic        tick;
    logic [7:0]  puntos;
    logic [1:0]  nivel;

    int n_checks = 0;
    int n_errors = 0;

    logic [20:0] exp_q[$];
    logic [9:0]  pts_q[$];

    logic [6:0] rom_tb [10] = '{
        7'b0001111, 7'b1100011, 7'b0111000, 7'b0010011, 7'b1000001,
        7'b0111111, 7'b0110110, 7'b0010101, 7'b0110001, 7'b1111110
    };

    // Reference model state
    int          m_presc;
    logic [20:0] m_disp;
    int          m_puntos;
    int          m_nivel;
    logic [7:0]  m_lfsr;
    logic        m_obs_next;
    logic [3:0]  m_prev;

    logic        last_tick;
    int          since;
    int          last_gap;
    int          tick_cnt;
    logic [6:0]  first_obs;

    generador_obstaculos #(
        .PER0(24'd8), .PER1(24'd6), .PER2(24'd4), .PER3(24'd2),
        .PTS_NIVEL(8'd2), .SEMILLA(8'hA5)
    ) dut (
        .clk_ob  (clk_ob),
        .rst     (rst),
        .presente(presente),
        .v_d     (v_d),
        .disp_obs(disp_obs),
        .tick    (tick),
        .puntos  (puntos),
        .nivel   (nivel)
    );

    initial clk_ob = 1'b0;
    always #5 clk_ob = ~clk_ob;

    function automatic int per_of(input int n);
        case (n)
            0:       return 8;
            1:       return 6;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic int idx_of(input logic [7:0] x);
        int n;
        n = int'(x[3:0]);
        return (n < 10) ? n : n - 10;
    endfunction

    task automatic model_reset();
        m_presc    = 0;
        m_disp     = '0;
        m_puntos   = 0;
        m_nivel    = 0;
        m_lfsr     = 8'hA5;
        m_obs_next = 1'b1;
        m_prev     = 4'd0;
    endtask

    // One clock: check tick at negedge, step the model, drain scoreboard after posedge.
    task automatic cycle();
        logic m_run;
        logic m_tick;
        logic m_clear;
        logic [6:0] ent;
        logic [20:0] ed;
        logic [9:0] ep;
        m_run   = (presente == 4'd3 || presente == 4'd4) && (v_d != 2'd1);
        m_tick  = !rst && m_run && (m_presc >= per_of(m_nivel) - 1);
        m_clear = (presente == 4'd0) || (presente == 4'd1 && m_prev != 4'd1);
        @(negedge clk_ob);
        n_checks++;
        if (tick !== m_tick) begin
            n_errors++;
            $display("FAIL tick_pulse t=%0t got=%b exp=%b", $time, tick, m_tick);
        end
        last_tick = tick;
        since++;
        if (tick === 1'b1) begin
            last_gap = since;
            since    = 0;
            tick_cnt++;
        end
        if (rst) begin
            model_reset();
        end else begin
            if (m_clear) begin
                m_presc = 0; m_disp = '0; m_puntos = 0; m_nivel = 0; m_obs_next = 1'b1;
            end else if (m_tick) begin
                ent = m_obs_next ? rom_tb[idx_of(m_lfsr)] : 7'b0;
                if (m_disp[6:0] != 7'b0 && m_puntos != 255) m_puntos++;
                m_disp     = {ent, m_disp[20:7]};
                m_obs_next = !m_obs_next;
                m_nivel    = (m_puntos / 2 > 3) ? 3 : m_puntos / 2;
                m_presc    = 0;
                exp_q.push_back(m_disp);
                pts_q.push_back({2'(m_nivel), 8'(m_puntos)});
            end else if (m_run) begin
                m_presc++;
            end
            if (m_run) m_lfsr = lfsr_step(m_lfsr);
            m_prev = presente;
        end
        @(posedge clk_ob);
        #1;
        if (last_tick === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_tick t=%0t disp=%h", $time, disp_obs);
            end else begin
                ed = exp_q.pop_front();
                ep = pts_q.pop_front();
                if (disp_obs !== ed) begin
                    n_errors++;
                    $display("FAIL sb_disp t=%0t got=%h exp=%h", $time, disp_obs, ed);
                end
                n_checks++;
                if ({nivel, puntos} !== ep) begin
                    n_errors++;
                    $display("FAIL sb_score t=%0t got niv=%0d pts=%0d exp niv=%0d pts=%0d",
                             $time, nivel, puntos, ep[9:8], ep[7:0]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; presente = 4'd0; v_d = 2'd0;
        cycle();
        cycle();
        n_checks++;
        if (disp_obs !== 21'd0 || puntos !== 8'd0 || nivel !== 2'd0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got disp=%h pts=%0d niv=%0d tick=%b exp all 0",
                     disp_obs, puntos, nivel, tick);
        end
        n_checks++;
        if (dut.u_lfsr.q !== 8'hA5) begin
            n_errors++;
            $display("FAIL reset_lfsr got=%h exp=a5", dut.u_lfsr.q);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_first_tick();
        int first;
        logic [7:0] l;
        first = 0;
        presente = 4'd3;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            cycle();
            if (last_tick === 1'b1) first = i;
        end
        n_checks++;
        if (first != 8) begin
            n_errors++;
            $display("FAIL first_tick_cycle got=%0d exp=8", first);
        end
        l = 8'hA5;
        for (int i = 0; i < 7; i++) l = lfsr_step(l);
        first_obs = rom_tb[idx_of(l)];
        n_checks++;
        if (disp_obs !== {first_obs, 14'd0}) begin
            n_errors++;
            $display("FAIL first_entry got=%h exp=%h", disp_obs, {first_obs, 14'd0});
        end
    endtask

    task automatic test_shift();
        for (int i = 0; i < 60 && tick_cnt < 4; i++) begin
            cycle();
            if (last_tick === 1'b1 && tick_cnt == 3) begin
                n_checks++;
                if (disp_obs[6:0] !== first_obs) begin
                    n_errors++;
                    $display("FAIL shift_third got=%b exp=%b", disp_obs[6:0], first_obs);
                end
            end
        end
        n_checks++;
        if (tick_cnt != 4 || puntos !== 8'd1) begin
            n_errors++;
            $display("FAIL shift_score got ticks=%0d pts=%0d exp ticks=4 pts=1", tick_cnt, puntos);
        end
    endtask

    task automatic test_freeze();
        logic [20:0] s_d;
        logic [7:0]  s_p;
        logic [1:0]  s_n;
        for (int i = 0; i < 20 && m_presc != per_of(m_nivel) - 1; i++) cycle();
        v_d = 2'd1;
        s_d = disp_obs; s_p = puntos; s_n = nivel;
        cycle();
        n_checks++;
        if (last_tick !== 1'b0 || disp_obs !== s_d || puntos !== s_p || nivel !== s_n) begin
            n_errors++;
            $display("FAIL freeze_hold got tick=%b disp=%h pts=%0d exp tick=0 disp=%h pts=%0d",
                     last_tick, disp_obs, puntos, s_d, s_p);
        end
        v_d = 2'd0;
        cycle();
        n_checks++;
        if (last_tick !== 1'b1) begin
            n_errors++;
            $display("FAIL freeze_release got tick=%b exp=1", last_tick);
        end
    endtask

    task automatic test_levels();
        int gap_seen [4];
        int nb;
        for (int i = 0; i < 4; i++) gap_seen[i] = 0;
        for (int i = 0; i < 600 && m_puntos < 8; i++) begin
            nb = m_nivel;
            cycle();
            if (last_tick === 1'b1) gap_seen[nb] = last_gap;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gap_seen[i] != per_of(i)) begin
                n_errors++;
                $display("FAIL level_gap niv=%0d got=%0d exp=%0d", i, gap_seen[i], per_of(i));
            end
        end
        n_checks++;
        if (nivel !== 2'd3 || puntos !== 8'd8) begin
            n_errors++;
            $display("FAIL level_saturate got niv=%0d pts=%0d exp niv=3 pts=8", nivel, puntos);
        end
    endtask

    task automatic test_clear();
        presente = 4'd0;
        cycle();
        cycle();
        presente = 4'd1;
        cycle();
        n_checks++;
        if (disp_obs !== 21'd0 || puntos !== 8'd0 || nivel !== 2'd0) begin
            n_errors++;
            $display("FAIL clear_outputs got disp=%h pts=%0d niv=%0d exp 0", disp_obs, puntos, nivel);
        end
        n_checks++;
        if (dut.u_lfsr.q !== m_lfsr || m_lfsr === 8'hA5) begin
            n_errors++;
            $display("FAIL clear_lfsr_kept got=%h exp=%h", dut.u_lfsr.q, m_lfsr);
        end
        presente = 4'd3;
        tick_cnt = 0;
        for (int i = 0; i < 12 && tick_cnt == 0; i++) cycle();
        n_checks++;
        if (tick_cnt != 1 || disp_obs[20:14] === 7'd0) begin
            n_errors++;
            $display("FAIL clear_restart got ticks=%0d entry=%b exp ticks=1 obstacle", tick_cnt,
                     disp_obs[20:14]);
        end
    endtask

    task automatic test_reset_mid();
        presente = 4'd4;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        n_checks++;
        if (disp_obs !== 21'd0 || puntos !== 8'd0 || nivel !== 2'd0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid got disp=%h pts=%0d niv=%0d tick=%b exp 0", disp_obs, puntos,
                     nivel, tick);
        end
        n_checks++;
        if (dut.u_lfsr.q !== 8'hA5) begin
            n_errors++;
            $display("FAIL reset_mid_lfsr got=%h exp=a5", dut.u_lfsr.q);
        end
        rst = 1'b0;
        presente = 4'd0;
        cycle();
    endtask

    initial begin
        rst = 1'b1; presente = 4'd0; v_d = 2'd0;
        since = 0; last_gap = 0; tick_cnt = 0; last_tick = 1'b0; first_obs = '0;
        model_reset();
        @(posedge clk_ob);
        #1;
        test_reset();
        tick_cnt = 0;
        test_first_tick();
        test_shift();
        test_freeze();
        test_levels();
        test_clear();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
